multiword_add_seq: RTL

//  Sequencer in front of the prefix-tree adder datapath: accepts a wide operand pair,

---
 rtl/mw_add_pkg.sv | 15 +
 rtl/mw_chunk_add.sv | 40 ++++
 rtl/multiword_add_seq.sv | 105 ++++++++++
 3 files changed

// File: rtl/mw_add_pkg.sv
// Shared types and width helpers for the multi-word sequential adder.
package mw_add_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   function automatic int total_w(input int word_w, input int num_words);
      return word_w * num_words;
   endfunction

   // Index counter is kept at least 1 bit wide so NUM_WORDS=1 still has a legal vector.
   function automatic int idx_w(input int num_words);
      return (num_words > 1) ? $clog2(num_words) : 1;
   endfunction

endpackage

// File: rtl/mw_chunk_add.sv
// Combinational WORD_W-bit adder with a Kogge-Stone prefix carry tree.
module mw_chunk_add #(
   parameter int WORD_W = 8
) (
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   input  logic              cin,
   output logic [WORD_W-1:0] sum,
   output logic              cout
);

   localparam int LVL = $clog2(WORD_W);

   logic [WORD_W-1:0] gk, pk, gn, pn, c;

   always_comb begin
      gk = a & b;
      pk = a ^ b;
      // Folding cin into bit 0's generate makes every prefix include the carry-in.
      gk[0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
      gn = gk;
      pn = pk;
      for (int l = 0; l < LVL; l++) begin
         gn = gk;
         pn = pk;
         for (int i = (1 << l); i < WORD_W; i++) begin
            gn[i] = gk[i] | (pk[i] & gk[i - (1 << l)]);
            pn[i] = pk[i] & pk[i - (1 << l)];
         end
         gk = gn;
         pk = pn;
      end
      c    = '0;
      c[0] = cin;
      for (int i = 1; i < WORD_W; i++) c[i] = gk[i-1];
      sum  = a ^ b ^ c;
      cout = gk[WORD_W-1];
   end

endmodule

// File: rtl/multiword_add_seq.sv
// Wide adder that feeds one WORD_W chunk per cycle (LSW first) through mw_chunk_add.
// Optional MW_ADD_SUB_EN adds a sub port for a - b (cout=1 means no borrow).
module multiword_add_seq
   import mw_add_pkg::*;
#(
   parameter  int WORD_W    = 8,
   parameter  int NUM_WORDS = 4,
   localparam int TOTAL_W   = total_w(WORD_W, NUM_WORDS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [TOTAL_W-1:0] a,
   input  logic [TOTAL_W-1:0] b,
   input  logic               cin,
`ifdef MW_ADD_SUB_EN
   input  logic               sub,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [TOTAL_W-1:0] sum,
   output logic               cout
);

   localparam int IDX_W = idx_w(NUM_WORDS);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_WORDS - 1);

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic               carry;
   logic               sub_r;
   logic               sub_in;
   logic [TOTAL_W-1:0] a_r, b_r;
   logic [WORD_W-1:0]  a_chunk, b_chunk, s_chunk;
   logic               c_chunk;
   logic               accept;

`ifdef MW_ADD_SUB_EN
   assign sub_in = sub;
`else
   assign sub_in = 1'b0;
`endif

   assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
   assign accept   = in_valid & in_ready;

   assign a_chunk = a_r[int'(idx)*WORD_W +: WORD_W];
   assign b_chunk = sub_r ? ~b_r[int'(idx)*WORD_W +: WORD_W] : b_r[int'(idx)*WORD_W +: WORD_W];

   mw_chunk_add #(.WORD_W(WORD_W)) u_chunk (
      .a    (a_chunk),
      .b    (b_chunk),
      .cin  (carry),
      .sum  (s_chunk),
      .cout (c_chunk)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         carry     <= 1'b0;
         sub_r     <= 1'b0;
         a_r       <= '0;
         b_r       <= '0;
         sum       <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
      end else if (accept) begin
         // Subtract is a + ~b + 1, so the injected carry replaces cin.
         state     <= RUN;
         idx       <= '0;
         a_r       <= a;
         b_r       <= b;
         sub_r     <= sub_in;
         carry     <= sub_in ? 1'b1 : cin;
         sum       <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               sum[int'(idx)*WORD_W +: WORD_W] <= s_chunk;
               carry <= c_chunk;
               if (idx == LAST) begin
                  cout      <= c_chunk;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
